mod_fetch: RTL
==============

MOD_FETCH -- requirements
Module: mod_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the first instruction address fetched after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 Port ie  output  1  SHALL be the instruction-enable to the instruction memory; high means iaddr is a valid request this cycle.
REQ-005 Port iaddr  output  32  SHALL be the word-aligned fetch address; bits [1:0] always 0.
REQ-006 Port iout  input  32  SHALL be the instruction word, valid exactly one cycle after the ie cycle that requested it.
REQ-007 Port redirect  input  1  SHALL be the single-cycle request to restart fetch.
REQ-008 Port redirect_pc  input  32  SHALL be the restart address, sampled when redirect=1; bits [1:0] ignored.
REQ-009 Port out_valid  output  1  SHALL indicate out_inst/out_pc hold a valid instruction for decode.
REQ-010 Port out_ready  input  1  SHALL indicate decode accepts the head entry this cycle.
REQ-011 Port out_inst  output  32  SHALL be the head instruction word.
REQ-012 Port out_pc  output  32  SHALL be the address of out_inst.

Function
REQ-013 A 2-entry FIFO SHALL buffer {pc, inst}; out_inst/out_pc/out_valid SHALL come directly from FIFO head registers.
REQ-014 pop = out_valid & out_ready; an entry SHALL be removed only on pop.
REQ-015 ie SHALL be 1 iff redirect=0 and (count + inflight - pop) < 2, where inflight=1 if a request issued last cycle is not killed.
REQ-016 iaddr SHALL equal the fetch PC register at all times; the PC SHALL advance by 4 only on an ie=1 cycle, wrapping 0xFFFFFFFC -> 0x00000000.
REQ-017 Latency: request in cycle N SHALL be written into the FIFO at end of N+1; out_valid for it SHALL be visible no earlier than N+2.
REQ-018 With out_ready held 1 and no redirect, throughput SHALL be one instruction per cycle after fill.
REQ-019 While out_valid=1 and out_ready=0, out_inst and out_pc SHALL remain stable.
REQ-020 Pop and write in the same cycle with count=2 SHALL not happen (REQ-015 prevents); with count=1 both SHALL occur and count stays 1.
REQ-021 redirect=1 in cycle R SHALL, at end of R: empty the FIFO, kill the in-flight response (its iout in R+1 is discarded), load PC with {redirect_pc[31:2],2'b00}; redirect takes priority over pop, write and issue.
REQ-022 After redirect in R: out_valid=0 in R+1, ie=1 with iaddr=redirect_pc in R+1, first new out_valid in R+3.
REQ-023 Back-to-back redirects SHALL each take effect; only the last redirect_pc is fetched.

Reset
REQ-024 While rst=0: ie=0, iaddr=RESET_PC, out_valid=0, out_inst=0, out_pc=0, FIFO count=0, inflight=0, asynchronously.
REQ-025 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions; no pre-reset data appears after release.
REQ-026 First ie=1 SHALL occur in the first cycle after rst deasserts, with iaddr=RESET_PC.

Configuration
REQ-027 Macro FETCH_PERF_EN: when defined, output stall_cycles (32 bits) SHALL count cycles with out_valid=1 and out_ready=0, saturating at 0xFFFFFFFF, reset to 0; when undefined the port and counter SHALL not exist and behaviour is otherwise identical.

Verification
REQ-028 Reset release, RESET_PC=0, out_ready=1, ROM word k = k -> iaddr 0,4,8,... one per cycle; out_pc/out_inst 0/0 two cycles after first ie, then 4/1, 8/2 consecutively.
REQ-029 Hold out_ready=0 for 10 cycles after first valid -> FIFO fills to 2, ie=0, out_pc stays 0x0; on release pcs 0x0,0x4,0x8 in order, no gap or duplicate.
REQ-030 redirect=1 with redirect_pc=0x103 while FIFO full -> next cycle out_valid=0, iaddr=0x100; out_pc=0x100 two cycles later; no old instruction emitted.
REQ-031 Redirect on two consecutive cycles to 0x200 then 0x300 -> only 0x300 stream appears.
REQ-032 PC at 0xFFFFFFF8, out_ready=1 -> out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-033 rst asserted while inflight=1 and FIFO count=1 -> all outputs at reset values immediately; after release stream restarts at RESET_PC; with FETCH_PERF_EN, stall_cycles=0.

Source files
------------

// File: rtl/mod_fetch.sv
// -----------------------------------------------------------------------------
// mod_fetch -- instruction fetch front end
//
// Issues word-aligned fetch requests to an instruction memory with a fixed
// one-cycle read latency and buffers the returned words, together with their
// addresses, in a 2-entry FIFO whose head registers drive decode directly.
// A single-cycle redirect flushes the buffer, kills any response still
// arriving, and restarts fetch at a new address.
//
// Parameters
//   RESET_PC     first instruction address fetched after reset
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   ie           instruction-memory request enable (iaddr valid this cycle)
//   iaddr        word-aligned fetch address (bits [1:0] always 0)
//   iout         instruction word, valid one cycle after the requesting ie
//   redirect     single-cycle request to restart fetch
//   redirect_pc  restart address, bits [1:0] ignored
//   out_valid    head entry holds a valid instruction for decode
//   out_ready    decode accepts the head entry this cycle
//   out_inst     head instruction word
//   out_pc       address of out_inst
//   stall_cycles (only with FETCH_PERF_EN) saturating count of cycles with
//                out_valid=1 and out_ready=0
//
// Configuration macro
//   FETCH_PERF_EN  adds the stall_cycles output and its counter
// -----------------------------------------------------------------------------
module mod_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ie,
  output logic [31:0] iaddr,
  input  logic [31:0] iout,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  // Fetch addresses are always word aligned, including the reset address.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] pc_r;            // next address to request
  logic        inflight_r;      // a request issued last cycle returns now
  logic [31:0] inflight_pc_r;   // address of that in-flight request
  logic [1:0]  count_r;         // FIFO occupancy, 0..2
  logic        head_valid_r;    // head entry valid (drives out_valid)
  logic [31:0] head_pc_r;
  logic [31:0] head_inst_r;
  logic [31:0] tail_pc_r;
  logic [31:0] tail_inst_r;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic        pop_s;
  logic        wr_s;
  logic [2:0]  occupancy_s;
  logic        ie_s;
  logic [31:0] pc_next_s;
  logic [1:0]  count_next_s;
  logic        head_valid_next_s;
  logic [31:0] head_pc_next_s;
  logic [31:0] head_inst_next_s;
  logic [31:0] tail_pc_next_s;
  logic [31:0] tail_inst_next_s;

  // Handshake, response write and issue decision for the current cycle.
  always_comb begin
    pop_s = head_valid_r & out_ready;
    // A returning response is dropped when a redirect lands in the same cycle.
    wr_s  = inflight_r & ~redirect;
    // Slots that will be committed after this cycle's pop. A pop implies
    // count_r >= 1, so the subtraction never underflows.
    occupancy_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    // Gating with rst keeps ie low asynchronously while reset is held.
    if (rst && !redirect && (occupancy_s < 3'd2)) begin
      ie_s = 1'b1;
    end else begin
      ie_s = 1'b0;
    end
  end

  // Next fetch PC: redirect wins, otherwise advance only on an issued request.
  always_comb begin
    pc_next_s = pc_r;
    if (redirect) begin
      pc_next_s = {redirect_pc[31:2], 2'b00};
    end else if (ie_s) begin
      pc_next_s = pc_r + 32'd4;   // wraps 0xFFFFFFFC -> 0x00000000 naturally
    end else begin
      pc_next_s = pc_r;
    end
  end

  // FIFO next state: head is the oldest entry, tail the second one.
  always_comb begin
    count_next_s     = count_r;
    head_pc_next_s   = head_pc_r;
    head_inst_next_s = head_inst_r;
    tail_pc_next_s   = tail_pc_r;
    tail_inst_next_s = tail_inst_r;
    if (redirect) begin
      // Flush only; stale data registers are harmless while invalid.
      count_next_s = 2'd0;
    end else begin
      case ({wr_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_pc_next_s   = inflight_pc_r;
            head_inst_next_s = iout;
            count_next_s     = 2'd1;
          end else begin
            tail_pc_next_s   = inflight_pc_r;
            tail_inst_next_s = iout;
            count_next_s     = 2'd2;
          end
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            head_pc_next_s   = tail_pc_r;
            head_inst_next_s = tail_inst_r;
            count_next_s     = 2'd1;
          end else begin
            count_next_s     = 2'd0;
          end
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            // Steady streaming: the new word replaces the departing head.
            head_pc_next_s   = inflight_pc_r;
            head_inst_next_s = iout;
            count_next_s     = 2'd1;
          end else begin
            // Unreachable because issue is throttled, kept ordered anyway.
            head_pc_next_s   = tail_pc_r;
            head_inst_next_s = tail_inst_r;
            tail_pc_next_s   = inflight_pc_r;
            tail_inst_next_s = iout;
            count_next_s     = 2'd2;
          end
        end
        default: begin
          count_next_s = count_r;
        end
      endcase
    end
    if (count_next_s != 2'd0) begin
      head_valid_next_s = 1'b1;
    end else begin
      head_valid_next_s = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Fetch PC and in-flight request tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r          <= RESET_PC_ALIGNED;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
    end else begin
      pc_r          <= pc_next_s;
      // ie is forced low under redirect, so a redirect never leaves a
      // request in flight.
      inflight_r    <= ie_s;
      if (ie_s) begin
        inflight_pc_r <= pc_r;
      end else begin
        inflight_pc_r <= inflight_pc_r;
      end
    end
  end

  // FIFO storage and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r      <= 2'd0;
      head_valid_r <= 1'b0;
      head_pc_r    <= 32'h0000_0000;
      head_inst_r  <= 32'h0000_0000;
      tail_pc_r    <= 32'h0000_0000;
      tail_inst_r  <= 32'h0000_0000;
    end else begin
      count_r      <= count_next_s;
      head_valid_r <= head_valid_next_s;
      head_pc_r    <= head_pc_next_s;
      head_inst_r  <= head_inst_next_s;
      tail_pc_r    <= tail_pc_next_s;
      tail_inst_r  <= tail_inst_next_s;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles_r;

  // Saturating count of cycles where decode back-pressures a valid head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_r <= 32'h0000_0000;
    end else if (head_valid_r && !out_ready && (stall_cycles_r != 32'hFFFF_FFFF)) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign stall_cycles = stall_cycles_r;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ie        = ie_s;
  assign iaddr     = pc_r;
  assign out_valid = head_valid_r;
  assign out_pc    = head_pc_r;
  assign out_inst  = head_inst_r;

endmodule
